image_stream_source: RTL and testbench
======================================

# image_stream_source

Streams a row-major 8-bit grayscale image from a synchronous-read pixel memory into the image-processing pipeline's AXI4-Stream slave input. It is the transmitting end of that interface: it drives the data/valid pair, honours the pipeline's ready, and paces delivery by line. It sends a preload burst of lines on start, then one further line per line-consumed interrupt pulse from the pipeline, and signals completion after the final line.

## Interface
- IMG_WIDTH, 512, pixels per line (≥2)
- IMG_HEIGHT, 512, lines per frame (≥1)
- PRELOAD_LINES, 4, lines sent on start without waiting for interrupts (1..IMG_HEIGHT)
- ADDR_W, 18, memory address width (≥ clog2(IMG_WIDTH*IMG_HEIGHT))
- axi_clk  in  1  sole clock, all logic rising-edge
- axi_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame start request, sampled only in IDLE
- o_busy  out  1  high from cycle after accepted start until frame completes
- o_done  out  1  one-cycle pulse at frame completion
- o_mem_en  out  1  memory read enable
- o_mem_addr  out  ADDR_W  memory read address
- i_mem_data  in  8  read data, valid exactly one cycle after o_mem_en
- o_data_valid  out  1  AXIS tvalid to pipeline
- o_data  out  8  AXIS tdata to pipeline
- i_data_ready  in  1  AXIS tready from pipeline
- i_intr  in  1  line-consumed pulse from pipeline (one line credit per high cycle)

## Operation
- States: IDLE, STREAM, WAIT, FINISH.
- IDLE: outputs quiet. i_start=1 → credit := PRELOAD_LINES, line := 0, col := 0 → STREAM.
- STREAM: issue reads for the current line, address = line*IMG_WIDTH + col, with col incrementing 0..IMG_WIDTH-1. Issue a read only if (output-buffer occupancy + reads in flight) < 2.
- Output buffer: 2-entry FIFO between memory data and the AXIS output. It guarantees one pixel per cycle under continuous ready and no data loss under backpressure.
- When the last read of a line is issued: line += 1 and credit -= 1.
  - line == IMG_HEIGHT → FINISH.
  - Otherwise, credit (after decrement, plus any same-cycle i_intr) > 0 → STREAM, col := 0.
  - Otherwise → WAIT.
- WAIT: no reads issued; the output buffer keeps draining. i_intr → credit += 1 → STREAM.
- FINISH: wait until the output buffer is empty and no read is in flight. Then pulse o_done, drop o_busy, go to IDLE.
- Credit counter: clog2(IMG_HEIGHT+1) bits, saturating at IMG_HEIGHT.
  - i_intr in STREAM, WAIT or FINISH increments it.
  - i_intr in IDLE is ignored.
  - Simultaneous i_intr and line-issue decrement leaves it unchanged.
- i_start outside IDLE is ignored; a frame is never restarted mid-flight.
- Pixel order on the stream is strictly row-major; no pixels are dropped, duplicated or reordered.

## Timing
- Reset (async assert, sync-safe release) sets: o_busy=0, o_done=0, o_mem_en=0, o_mem_addr=0, o_data_valid=0, o_data=0; state=IDLE; credit=0; buffer emptied; any in-flight read discarded.
- Reset mid-frame aborts without an o_done pulse.
- Start sampled at edge N: o_busy=1 and o_mem_en=1 with addr 0 after N+1; o_data_valid=1 with pixel 0 after N+2.
- With i_data_ready held high and enough credit: one pixel per cycle. A frame completes at edge N+2+IMG_WIDTH*IMG_HEIGHT, with o_done high for the following cycle.
- AXIS rules:
  - Once o_data_valid is asserted, o_data_valid and o_data hold until the handshake (valid & ready).
  - o_data_valid never depends combinationally on i_data_ready.
- Ready deasserted: at most 2 pixels outstanding, and reads stall within one cycle.
- Ready reasserted: streaming resumes at full rate with no bubble beyond buffer refill.
- o_done coincides with the first cycle of o_busy=0.

## Test plan
- Bench parameters IMG_WIDTH=8, IMG_HEIGHT=6, PRELOAD_LINES=4; memory holds addr[7:0].
- Basic frame: ready=1, i_intr pulsed once after each line's last handshake.
  - Stream carries 0..47 in order, one per cycle.
  - o_done pulses once, 50 cycles after start.
- Credit pacing: no i_intr.
  - Exactly 32 pixels (0..31) are sent, then the block stays in WAIT with o_busy=1.
  - Two i_intr pulses release pixels 32..47, then o_done.
- Backpressure: random 50% ready.
  - All 48 pixels arrive in order.
  - valid/data are stable across every stalled cycle, and no read is issued while occupancy + in-flight = 2.
- Simultaneous events:
  - i_intr in the same cycle as line 3's last read issue: no WAIT entry, and credit count is checked.
  - i_intr while IDLE does not raise credit for the next frame.
- Reset mid-frame: drop axi_reset_n after pixel 20.
  - All outputs are 0 immediately, with no o_done.
  - A new start re-streams from pixel 0.
- Start ignored while busy: pulse i_start at pixel 10; the frame is unaffected and exactly one o_done is produced.

Source files
------------

// File: rtl/image_stream_source_if.sv
// AXI4-Stream byte channel between the image source and the pipeline.
// The source drives data/valid; the pipeline drives ready.
interface image_stream_source_if;
  logic       o_data_valid;
  logic [7:0] o_data;
  logic       i_data_ready;

  modport master (
    output o_data_valid,
    output o_data,
    input  i_data_ready
  );

  modport slave (
    input  o_data_valid,
    input  o_data,
    output i_data_ready
  );
endinterface

// File: rtl/image_stream_source.sv
// Row-major grayscale image streamer: sync-read pixel memory to AXIS,
// paced by line credits (preload burst, then one line per interrupt).
module image_stream_source #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int PRELOAD_LINES = 4,
  parameter int ADDR_W        = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  image_stream_source_if.master axis,
  input  logic              i_intr
);

  localparam int CW = $clog2(IMG_HEIGHT + 1);
  localparam int XW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [CW-1:0] C_MAX  = CW'(IMG_HEIGHT);
  localparam logic [CW-1:0] C_PRE  = CW'(PRELOAD_LINES);
  localparam logic [CW-1:0] L_LAST = CW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_credit;
  logic [CW-1:0]     r_line;
  logic [XW-1:0]     r_col;
  logic [ADDR_W-1:0] r_pix;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rd_vld;
  logic [7:0]        r_buf0;
  logic [7:0]        r_buf1;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;

  logic              w_valid;
  logic [7:0]        w_head;
  logic              w_hs;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_eol;
  logic              w_inc;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_credit_n;

  // Output head: buffered pixel first, else bypass the fresh memory word.
  assign w_valid = (r_cnt != 2'd0) | r_rd_vld;
  assign w_head  = (r_cnt == 2'd0) ? i_mem_data
                 : (r_rp ? r_buf1 : r_buf0);
  assign w_hs    = w_valid & axis.i_data_ready;

  assign axis.o_data_valid = w_valid;
  assign axis.o_data       = w_valid ? w_head : 8'd0;

  // Pixels held or on their way once this cycle's handshake is retired.
  assign w_occ = 3'(r_cnt) + 3'(r_rd_vld)
               + 3'(r_mem_en) - 3'(w_hs);

  assign w_issue = (r_state == S_STREAM) && (w_occ < 3'd2);
  assign w_eol   = w_issue && (r_col == X_LAST);
  assign w_inc   = i_intr && (r_state != S_IDLE);

  assign w_push = r_rd_vld && !(w_hs && (r_cnt == 2'd0));
  assign w_pop  = w_hs && (r_cnt != 2'd0);

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_mem_en   = r_mem_en;
  assign o_mem_addr = r_mem_addr;

  // Line credit update: interrupt adds, line issue spends, both cancel.
  always_comb begin
    w_credit_n = r_credit;
    if (w_inc && !w_eol) begin
      if (r_credit != C_MAX) begin
        w_credit_n = r_credit + CW'(1);
      end
    end else if (!w_inc && w_eol) begin
      w_credit_n = r_credit - CW'(1);
    end
  end

  // Frame sequencing, read issue and line/credit bookkeeping.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_line     <= '0;
      r_col      <= '0;
      r_pix      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_done   <= 1'b0;
      r_mem_en <= w_issue;
      r_credit <= w_credit_n;
      if (w_issue) begin
        r_mem_addr <= r_pix;
        r_pix      <= r_pix + ADDR_W'(1);
        r_col      <= w_eol ? '0 : r_col + XW'(1);
      end
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_STREAM;
            r_busy   <= 1'b1;
            r_credit <= C_PRE;
            r_line   <= '0;
            r_col    <= '0;
            r_pix    <= '0;
          end
        end
        S_STREAM: begin
          if (w_eol) begin
            r_line <= r_line + CW'(1);
            if (r_line == L_LAST) begin
              r_state <= S_FINISH;
            end else if (w_credit_n == '0) begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_intr) begin
            r_state <= S_STREAM;
          end
        end
        S_FINISH: begin
          if (w_occ == 3'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-data pipe and 2-entry skid buffer feeding the stream.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_rd_vld <= 1'b0;
      r_buf0   <= 8'd0;
      r_buf1   <= 8'd0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_rd_vld <= r_mem_en;
      if (w_push) begin
        if (r_wp) begin
          r_buf1 <= i_mem_data;
        end else begin
          r_buf0 <= i_mem_data;
        end
        r_wp <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  a_hold: assert property (
    @(posedge axi_clk) disable iff (!axi_reset_n)
    (w_valid && !axis.i_data_ready)
      |=> (w_valid && $stable(axis.o_data))
  );

  a_no_overflow: assert property (
    @(posedge axi_clk) disable iff (!axi_reset_n)
    !((r_cnt == 2'd2) && r_rd_vld)
  );

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: 8x6 frame, memory returns addr[7:0].
// Stream/credit/address model in a negedge monitor plus directed cases.
module tb_image_stream_source;
  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_mem_en;
  logic [17:0] o_mem_addr;
  logic [7:0]  mem_q = 8'd0;
  logic        intr_man;
  logic        intr_auto = 1'b0;
  logic        i_intr;
  logic        auto_on;
  int          rdy_mode;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  int m_pix = 0;
  int m_iss = 0;
  int m_intr = 0;
  bit m_pv = 0;
  bit m_pr = 0;
  bit m_pb = 0;
  int m_pd = 0;

  image_stream_source_if axis();

  assign i_intr = intr_man | intr_auto;

  image_stream_source #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PRELOAD_LINES(P), .ADDR_W(18)
  ) dut (
    .axi_clk(clk),
    .axi_reset_n(rst_n),
    .i_start(i_start),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_mem_en(o_mem_en),
    .o_mem_addr(o_mem_addr),
    .i_mem_data(mem_q),
    .axis(axis),
    .i_intr(i_intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_en) mem_q <= o_mem_addr[7:0];
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Model: row-major pixel sequence, address sequence, credit bound, AXIS hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pv = 0; m_pb = 0; m_pix = 0; m_iss = 0; m_intr = 0;
      end else begin
        if (o_busy && !m_pb) begin
          m_pix = 0; m_iss = 0; m_intr = 0;
        end
        if (o_busy && i_intr) m_intr++;
        if (o_mem_en) begin
          chk("mem_addr", int'(o_mem_addr), m_iss);
          chk("rd_gate_lt2", int'((m_iss - m_pix) < 2), 1);
          m_iss++;
        end
        if (m_pv && !m_pr) begin
          chk("hold_valid", int'(axis.o_data_valid), 1);
          chk("hold_data", int'(axis.o_data), m_pd);
        end
        if (axis.o_data_valid) begin
          chk("pix_data", int'(axis.o_data), m_pix % 256);
          chk("credit_bound",
              int'((m_pix / W) < ((P + m_intr > H) ? H : P + m_intr)), 1);
          if (axis.i_data_ready) m_pix++;
        end
        if (o_done) begin
          n_done++;
          chk("done_all_pixels", m_pix, W * H);
          chk("done_busy_low", int'(o_busy), 0);
        end
        m_pv = axis.o_data_valid;
        m_pr = axis.i_data_ready;
        m_pd = int'(axis.o_data);
        m_pb = o_busy;
      end
    end
  end

  // Ready pattern: 0 = always, 1 = random 50%.
  initial begin
    axis.i_data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      axis.i_data_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end
  end

  // Line-consumed interrupt after each line's last handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_on && rst_n && axis.o_data_valid && axis.i_data_ready
          && axis.o_data[2:0] == 3'd7) begin
        @(posedge clk); #1 intr_auto = 1'b1;
        @(posedge clk); #1 intr_auto = 1'b0;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic pulse_intr();
    @(posedge clk); #1 intr_man = 1'b1;
    @(posedge clk); #1 intr_man = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    bit seen;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done) seen = 1;
    end
    chk("done_in_time", int'(seen), 1);
  endtask

  task automatic wait_pix(input int n, input int budget);
    int c;
    c = 0;
    while (m_pix < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("pix_in_time", int'(m_pix >= n), 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_mem_en"}, int'(o_mem_en), 0);
    chk({tag, "_mem_addr"}, int'(o_mem_addr), 0);
    chk({tag, "_valid"}, int'(axis.o_data_valid), 0);
    chk({tag, "_data"}, int'(axis.o_data), 0);
  endtask

  initial begin
    int cyc;
    int d0;
    int t40;
    rst_n = 1'b0; i_start = 1'b0; intr_man = 1'b0;
    auto_on = 1'b0; rdy_mode = 0;
    #12;
    chk_quiet("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic frame at full rate.
    auto_on = 1'b1; d0 = n_done;
    start_frame();
    chk("start_busy", int'(o_busy), 1);
    chk("start_no_rd", int'(o_mem_en), 0);
    @(posedge clk); #1;
    chk("rd0_en", int'(o_mem_en), 1);
    chk("rd0_addr", int'(o_mem_addr), 0);
    chk("rd0_no_valid", int'(axis.o_data_valid), 0);
    @(posedge clk); #1;
    chk("px0_valid", int'(axis.o_data_valid), 1);
    chk("px0_data", int'(axis.o_data), 0);
    wait_done(200, cyc);
    chk("basic_done_cycle", cyc + 2, 50);
    chk("basic_pixels", m_pix, 48);
    chk("basic_busy_off", int'(o_busy), 0);
    repeat (10) @(posedge clk);
    chk("basic_one_done", n_done - d0, 1);

    // Credit pacing; interrupts while idle must not add credit.
    auto_on = 1'b0; d0 = n_done;
    @(posedge clk); #1 intr_man = 1'b1;
    repeat (3) @(posedge clk);
    #1 intr_man = 1'b0;
    start_frame();
    repeat (150) @(posedge clk);
    #1;
    chk("pace_stop_pixels", m_pix, 32);
    chk("pace_wait_busy", int'(o_busy), 1);
    chk("pace_wait_novalid", int'(axis.o_data_valid), 0);
    pulse_intr();
    repeat (40) @(posedge clk);
    #1;
    chk("pace_one_line", m_pix, 40);
    chk("pace_still_busy", int'(o_busy), 1);
    pulse_intr();
    wait_done(100, cyc);
    chk("pace_pixels", m_pix, 48);
    repeat (5) @(posedge clk);
    chk("pace_one_done", n_done - d0, 1);

    // Interrupt coincident with line 3's last read issue.
    d0 = n_done; t40 = 0;
    start_frame();
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk); #1;
      intr_man = (c == 31);
      if (t40 == 0 && m_pix == 40) t40 = c;
    end
    chk("simul_no_wait_gap", t40, 42);
    chk("simul_credit_lines", m_pix, 40);
    chk("simul_busy", int'(o_busy), 1);
    pulse_intr();
    wait_done(100, cyc);
    chk("simul_pixels", m_pix, 48);
    repeat (5) @(posedge clk);
    chk("simul_one_done", n_done - d0, 1);

    // Random backpressure.
    auto_on = 1'b1; rdy_mode = 1; d0 = n_done;
    start_frame();
    wait_done(2000, cyc);
    chk("bp_pixels", m_pix, 48);
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    chk("bp_one_done", n_done - d0, 1);

    // Reset mid-frame, then a clean restart.
    d0 = n_done;
    start_frame();
    wait_pix(20, 200);
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    repeat (5) @(posedge clk);
    chk("midrst_no_done", n_done - d0, 0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    start_frame();
    @(posedge clk); #1;
    chk("restart_addr0", int'(o_mem_addr), 0);
    @(posedge clk); #1;
    chk("restart_px0_valid", int'(axis.o_data_valid), 1);
    chk("restart_px0_data", int'(axis.o_data), 0);
    wait_done(200, cyc);
    chk("restart_pixels", m_pix, 48);
    repeat (10) @(posedge clk);
    chk("restart_one_done", n_done - d0, 1);

    // Start while busy is ignored.
    d0 = n_done;
    start_frame();
    wait_pix(10, 200);
    start_frame();
    wait_done(200, cyc);
    chk("busy_start_pixels", m_pix, 48);
    repeat (60) @(posedge clk);
    #1;
    chk("busy_start_one_done", n_done - d0, 1);
    chk("busy_start_idle", int'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
